// File: rtl/sensor_scan_pkg.sv
// Shared definitions for the sensor-scan control unit: state codes and index-width helper.
package sensor_scan_pkg;

    typedef enum logic [3:0] {
        INICIAL     = 4'd0,
        RESET       = 4'd1,
        MEDIR       = 4'd2,
        ESPERA      = 4'd3,
        MOVE        = 4'd4,
        ENVIA       = 4'd5,
        AGUARDA_TX  = 4'd6,
        PROX_BYTE   = 4'd7,
        PROX_SENSOR = 4'd8,
        FINAL       = 4'd9,
        ERRO        = 4'd10,
        ILEGAL      = 4'hF
    } state_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sensor_scan_uc_scan_counter.sv
// Modulo-MODULO up-counter with synchronous clear, enable and terminal-count flag.
module scan_counter
    import sensor_scan_pkg::*;
#(
    parameter int MODULO = 4,
    parameter int WIDTH  = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULO - 1);

    assign tc = (count == LAST);

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/sensor_scan_uc.sv
// Scan/servo/serial sequencing control unit. Optional TX timeout to ERRO is built
// only when UC_TX_TIMEOUT_EN is defined.
module sensor_scan_uc
    import sensor_scan_pkg::*;
#(
    parameter int N_SENSORS        = 3,
    parameter int BYTES_PER_SENSOR = 4,
    parameter int SETTLE_CYCLES    = 50000000,
    parameter int TX_TIMEOUT       = 1000000
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                jogar,
    input  logic                                continuo,
    input  logic                                parar,
    input  logic                                pronto_serial,
    output logic                                zera_sensor,
    output logic                                zera_serial,
    output logic                                zera_servos,
    output logic                                zera_disc,
    output logic                                medir,
    output logic                                carrega_disc,
    output logic                                partida_tx,
    output logic [idx_w(N_SENSORS)-1:0]         sensor_idx,
    output logic [idx_w(BYTES_PER_SENSOR)-1:0]  byte_idx,
    output logic                                pronto,
    output logic                                erro_timeout,
    output logic [3:0]                          db_estado
);

    localparam int SW = idx_w(N_SENSORS);
    localparam int BW = idx_w(BYTES_PER_SENSOR);
    localparam int TW = idx_w(SETTLE_CYCLES);

    state_t          state;
    logic            settle_tc, byte_tc, sensor_tc, to_tc;
    logic [TW-1:0]   settle_cnt;
    logic            unused_cnt;

    scan_counter #(.MODULO(SETTLE_CYCLES), .WIDTH(TW)) u_settle (
        .clock(clock), .reset(reset),
        .clr(state == MEDIR), .en(state == ESPERA),
        .count(settle_cnt), .tc(settle_tc)
    );

    // Byte index only advances when not already on the last byte of the sensor.
    scan_counter #(.MODULO(BYTES_PER_SENSOR), .WIDTH(BW)) u_byte (
        .clock(clock), .reset(reset),
        .clr(state == RESET || state == PROX_SENSOR),
        .en(state == PROX_BYTE && !byte_tc),
        .count(byte_idx), .tc(byte_tc)
    );

    scan_counter #(.MODULO(N_SENSORS), .WIDTH(SW)) u_sensor (
        .clock(clock), .reset(reset),
        .clr(state == RESET || state == FINAL),
        .en(state == PROX_SENSOR && !sensor_tc),
        .count(sensor_idx), .tc(sensor_tc)
    );

`ifdef UC_TX_TIMEOUT_EN
    localparam int OW = idx_w(TX_TIMEOUT);
    logic [OW-1:0] to_cnt;

    scan_counter #(.MODULO(TX_TIMEOUT), .WIDTH(OW)) u_timeout (
        .clock(clock), .reset(reset),
        .clr(state == ENVIA), .en(state == AGUARDA_TX),
        .count(to_cnt), .tc(to_tc)
    );
    assign unused_cnt = ^{settle_cnt, to_cnt};
`else
    assign to_tc      = 1'b0;
    assign unused_cnt = ^{settle_cnt, (TX_TIMEOUT > 0)};
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= INICIAL;
        end else begin
            case (state)
                INICIAL:     if (jogar) state <= RESET;
                RESET:       state <= MEDIR;
                MEDIR:       state <= ESPERA;
                ESPERA:      if (settle_tc) state <= MOVE;
                MOVE:        state <= ENVIA;
                ENVIA:       state <= AGUARDA_TX;
                // A done pulse in the terminal timeout cycle still counts as success.
                AGUARDA_TX:  if (pronto_serial) state <= PROX_BYTE;
                             else if (to_tc) state <= ERRO;
                PROX_BYTE:   state <= byte_tc ? PROX_SENSOR : ENVIA;
                PROX_SENSOR: state <= sensor_tc ? FINAL : ENVIA;
                FINAL:       state <= (continuo && !parar) ? MEDIR : INICIAL;
                ERRO:        if (jogar) state <= RESET;
                default:     state <= INICIAL;
            endcase
        end
    end

    always_comb begin
        zera_sensor  = 1'b0;
        zera_serial  = 1'b0;
        zera_servos  = 1'b0;
        zera_disc    = 1'b0;
        medir        = 1'b0;
        carrega_disc = 1'b0;
        partida_tx   = 1'b0;
        pronto       = 1'b0;
        erro_timeout = 1'b0;
        db_estado    = state;
        case (state)
            INICIAL, ESPERA, AGUARDA_TX, PROX_BYTE, PROX_SENSOR: ;
            RESET: begin
                zera_sensor = 1'b1;
                zera_serial = 1'b1;
                zera_servos = 1'b1;
                zera_disc   = 1'b1;
            end
            MEDIR:  medir        = 1'b1;
            MOVE:   carrega_disc = 1'b1;
            ENVIA:  partida_tx   = 1'b1;
            FINAL:  pronto       = 1'b1;
`ifdef UC_TX_TIMEOUT_EN
            ERRO:   erro_timeout = 1'b1;
`else
            ERRO: ;
`endif
            default: db_estado = 4'hF;
        endcase
    end

endmodule

// File: doc/sensor_scan_uc.md
Name: sensor_scan_uc

Overview:
Parametrised successor control unit for the sensor-scan/servo/serial game loop. On start it clears the datapath, triggers a measurement and waits an internal settle time. It then loads the servo/display registers and transmits BYTES_PER_SENSOR bytes for each of N_SENSORS sensors through the serial TX handshake. Byte and sensor counters are internal, the unit supports a continuous (free-running) mode, and a TX timeout leads to an error state.

Parameters:
N_SENSORS, 3, number of sensors scanned per cycle (>=1)
BYTES_PER_SENSOR, 4, serial bytes sent per sensor (>=1)
SETTLE_CYCLES, 50000000, clock cycles waited in ESPERA after medir (>=1)
TX_TIMEOUT, 1000000, max cycles in AGUARDA_TX before error (>=1; used only with UC_TX_TIMEOUT_EN)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high; forces INICIAL and all counters to 0
jogar  in  1  start request, sampled in INICIAL and ERRO only
continuo  in  1  continuous mode, sampled in FINAL
parar  in  1  stop request, sampled in FINAL; overrides continuo
pronto_serial  in  1  TX done pulse, sampled in AGUARDA_TX only
zera_sensor, zera_serial, zera_servos, zera_disc  out  1 each  datapath clears, high in RESET
medir  out  1  measurement trigger, high in MEDIR
carrega_disc  out  1  servo/display load, high in MOVE
partida_tx  out  1  single-cycle TX start, high in ENVIA
sensor_idx  out  max(1,$clog2(N_SENSORS))  sensor whose data is being sent
byte_idx  out  max(1,$clog2(BYTES_PER_SENSOR))  byte index within sensor
pronto  out  1  one-cycle end-of-scan pulse, high in FINAL
erro_timeout  out  1  high while in ERRO
db_estado  out  4  state code for debug display

Behaviour:
- Clocking: one clock (clock). reset is synchronous and active-high. Moore outputs are decoded from registered state only.
- Reset values: state INICIAL. Counters sensor_idx, byte_idx, settle and timeout are 0. All outputs are 0 and db_estado=0.
- States, with db_estado code and transitions:
  - INICIAL (0): goes to RESET if jogar.
  - RESET (1): clears pulse high, counters zeroed; goes to MEDIR.
  - MEDIR (2): medir=1, settle counter cleared; goes to ESPERA.
  - ESPERA (3): settle counter increments; goes to MOVE when count==SETTLE_CYCLES-1, so the state lasts exactly SETTLE_CYCLES cycles.
  - MOVE (4): carrega_disc=1; goes to ENVIA.
  - ENVIA (5): partida_tx=1 for exactly one cycle, timeout counter cleared; goes to AGUARDA_TX.
  - AGUARDA_TX (6): if pronto_serial, goes to PROX_BYTE; if timed out (feature on), goes to ERRO; otherwise stays.
  - PROX_BYTE (7): if byte_idx==BYTES_PER_SENSOR-1, goes to PROX_SENSOR; otherwise byte_idx++ and goes to ENVIA.
  - PROX_SENSOR (8): byte_idx<=0. If sensor_idx==N_SENSORS-1, goes to FINAL; otherwise sensor_idx++ and goes to ENVIA.
  - FINAL (9): pronto=1, sensor_idx<=0. If continuo&&!parar, goes to MEDIR; otherwise goes to INICIAL.
  - ERRO (10): erro_timeout=1; goes to RESET on jogar. Only jogar or reset leave ERRO.
  - Any illegal encoding goes to INICIAL next cycle, with db_estado=4'hF.
- Scan length: one scan issues exactly N_SENSORS*BYTES_PER_SENSOR partida_tx pulses. Indices are stable from ENVIA through PROX_BYTE.
- pronto_serial arriving outside AGUARDA_TX is ignored, including in the same cycle as partida_tx.
- jogar while busy is ignored.
- Continuous mode skips RESET: datapath is not re-cleared between scans.
- Degenerate N_SENSORS=1 and BYTES_PER_SENSOR=1: index outputs are 1 bit and stay 0.
- reset mid-scan aborts on the next edge; no further partida_tx is issued.

Optional Feature:
UC_TX_TIMEOUT_EN
- Defined: a counter runs in AGUARDA_TX; reaching TX_TIMEOUT-1 without pronto_serial moves the unit to ERRO. pronto_serial in that same cycle wins, going to PROX_BYTE.
- Undefined: no timeout counter is built, AGUARDA_TX waits indefinitely, ERRO is unreachable and erro_timeout is tied 0.

Decomposition:
- Shared package sensor_scan_pkg: state encoding constants (INICIAL..ERRO, ILEGAL=4'hF) and the index-width function (max(1,$clog2(n))).
- One sub-module: scan_counter, a parametrised modulo counter with clear, enable and terminal-count outputs. It is instantiated for settle, timeout, byte and sensor.

Test Plan:
- N=3, B=4, SETTLE=5, one jogar pulse -> zera_* high 1 cycle; medir 1 cycle; ESPERA exactly 5 cycles; then 12 partida_tx pulses with (sensor,byte) going (0,0)..(2,3) as pronto_serial is returned 3 cycles after each pulse; then pronto for 1 cycle and back to INICIAL.
- continuo=1 for 2 scans, then parar=1 -> FINAL goes to MEDIR twice without zera_*; after parar, FINAL goes to INICIAL; total 36 partida_tx pulses.
- UC_TX_TIMEOUT_EN, TX_TIMEOUT=8, pronto_serial withheld -> ERRO entered 8 cycles after AGUARDA_TX entry, erro_timeout=1, db_estado=10; a later jogar restarts from RESET.
- pronto_serial held high across ENVIA -> the ENVIA-cycle sample is ignored and the byte advances only on the AGUARDA_TX sample; pronto_serial pulsed while in INICIAL has no effect.
- reset asserted in AGUARDA_TX at byte (1,2) -> next cycle state 0, indices 0, all outputs 0; no further partida_tx pulses.
- N=1, B=1 -> one jogar gives exactly 1 partida_tx pulse, then pronto.
